frame_buf_sched: RTL and testbench

Triple-buffer frame scheduler for the 4-port SDRAM controller. It sits between the camera capture path and the display path and assigns each frame to one of three SDRAM frame buffers. The camera always writes a buffer the display is not reading, and the display always starts a new frame on the newest complete buffer. It drives the write-1 and read-1 start/max addresses and load pulses, sampling both vsyncs in the SDRAM control clock domain.

---
 rtl/frame_buf_sched.sv | 255 +++++++++++++++++++++++++
 tb/tb_frame_buf_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buf_sched.sv
// frame_buf_sched: triple-buffer frame scheduler between camera capture and display.
// Purpose: picks write, ready and read buffers, and drives the start/max addresses and reload pulses.
// Latency: 5 Clk cycles from a vsync edge to its load pulse. Addresses become valid on the first load cycle.
// Backpressure: none. Vsync events are never stalled. A pending frame that is overwritten is counted as dropped.
// Optional build macro FRAME_BUF_SCHED_STATS_EN enables the drop/repeat counters; without it both read 0.
module frame_buf_sched #(
  parameter int unsigned FRAME_SIZE  = 921600,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned ADDR_W      = 24,
  parameter logic        VS_POL      = 1'b1,
  parameter int unsigned LOAD_CYCLES = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              En,
  input  logic              wr_vsync,
  input  logic              rd_vsync,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] wr_max_addr,
  output logic              wr_load,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] rd_max_addr,
  output logic              rd_load,
  output logic [1:0]        wr_idx,
  output logic [1:0]        rd_idx,
  output logic [1:0]        rdy_idx,
  output logic              rdy_valid,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       rep_cnt
);

  // Buffer boundaries. Entry k is the start of buffer k, and entry k+1 is its max address.
  localparam logic [ADDR_W-1:0] BUF0_ADDR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] BUF1_ADDR = ADDR_W'(BASE_ADDR + FRAME_SIZE);
  localparam logic [ADDR_W-1:0] BUF2_ADDR = ADDR_W'(BASE_ADDR + 2 * FRAME_SIZE);
  localparam logic [ADDR_W-1:0] BUF3_ADDR = ADDR_W'(BASE_ADDR + 3 * FRAME_SIZE);
  localparam logic [3:0]        LOAD_INIT = 4'(LOAD_CYCLES);
  localparam logic [2:0]        VS_IDLE   = {3{~VS_POL}};

  // Constant-multiply by buffer index, done as a 3-entry mux.
  function automatic logic [ADDR_W-1:0] buf_addr(input logic [1:0] idx, input logic upper);
    case (idx)
      2'd0:    return upper ? BUF1_ADDR : BUF0_ADDR;
      2'd1:    return upper ? BUF2_ADDR : BUF1_ADDR;
      2'd2:    return upper ? BUF3_ADDR : BUF2_ADDR;
      default: return BUF0_ADDR;
    endcase
  endfunction

  // Synchronizers. Bits [1:0] are the 2-flop synchronizer, and bit [2] is the edge register.
  logic [1:0] en_sync_q, en_sync_d;
  logic [2:0] wr_vs_q, wr_vs_d;
  logic [2:0] rd_vs_q, rd_vs_d;
  logic       en_on;
  logic       wr_edge, rd_edge;

  // Scheduler state.
  logic [1:0] wr_idx_q, wr_idx_d;
  logic [1:0] rd_idx_q, rd_idx_d;
  logic [1:0] rdy_idx_q, rdy_idx_d;
  logic       rdy_valid_q, rdy_valid_d;
  logic       wr_started_q, wr_started_d;
  logic       wr_evt_q, wr_evt_d;
  logic       rd_evt_q, rd_evt_d;
  logic       wr_fire_q, wr_fire_d;
  logic       rd_fire_q, rd_fire_d;

  // Output stage.
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] wr_max_q, wr_max_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] rd_max_q, rd_max_d;
  logic [3:0]        wr_load_cnt_q, wr_load_cnt_d;
  logic [3:0]        rd_load_cnt_q, rd_load_cnt_d;

  assign en_on   = en_sync_q[1];
  assign wr_edge = (wr_vs_q[1] == VS_POL) && (wr_vs_q[2] != VS_POL);
  assign rd_edge = (rd_vs_q[1] == VS_POL) && (rd_vs_q[2] != VS_POL);

  // Shift the asynchronous inputs through their synchronizer chains.
  always_comb begin
    en_sync_d = {en_sync_q[0], En};
    wr_vs_d   = {wr_vs_q[1:0], wr_vsync};
    rd_vs_d   = {rd_vs_q[1:0], rd_vsync};
  end

  // Synchronizer registers. The vsync chains reset to the inactive level so no edge is seen out of reset.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      en_sync_q <= 2'b00;
      wr_vs_q   <= VS_IDLE;
      rd_vs_q   <= VS_IDLE;
    end else begin
      en_sync_q <= en_sync_d;
      wr_vs_q   <= wr_vs_d;
      rd_vs_q   <= rd_vs_d;
    end
  end

  // Buffer rotation. A read is applied first, then a write is applied to the post-read indices.
  always_comb begin
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    rdy_idx_d    = rdy_idx_q;
    rdy_valid_d  = rdy_valid_q;
    wr_started_d = wr_started_q;
    wr_evt_d     = en_on && wr_edge;
    rd_evt_d     = en_on && rd_edge;
    wr_fire_d    = wr_evt_q;
    rd_fire_d    = rd_evt_q;

    // Display takes the newest complete frame. Its old buffer becomes the spare.
    if (rd_evt_q && rdy_valid_q) begin
      rd_idx_d    = rdy_idx_q;
      rdy_idx_d   = rd_idx_q;
      rdy_valid_d = 1'b0;
    end

    // The first camera vsync only starts capture. Later ones publish the finished frame.
    if (wr_evt_q) begin
      if (!wr_started_q) begin
        wr_started_d = 1'b1;
      end else begin
        rdy_idx_d   = wr_idx_q;
        rdy_valid_d = 1'b1;
        wr_idx_d    = 2'd3 - rd_idx_d - wr_idx_q;
      end
    end

    // When disabled, all scheduler state returns to its reset values synchronously.
    if (!en_on) begin
      wr_idx_d     = 2'd0;
      rdy_idx_d    = 2'd1;
      rd_idx_d     = 2'd2;
      rdy_valid_d  = 1'b0;
      wr_started_d = 1'b0;
      wr_evt_d     = 1'b0;
      rd_evt_d     = 1'b0;
      wr_fire_d    = 1'b0;
      rd_fire_d    = 1'b0;
    end
  end

  // Scheduler registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_idx_q     <= 2'd0;
      rdy_idx_q    <= 2'd1;
      rd_idx_q     <= 2'd2;
      rdy_valid_q  <= 1'b0;
      wr_started_q <= 1'b0;
      wr_evt_q     <= 1'b0;
      rd_evt_q     <= 1'b0;
      wr_fire_q    <= 1'b0;
      rd_fire_q    <= 1'b0;
    end else begin
      wr_idx_q     <= wr_idx_d;
      rdy_idx_q    <= rdy_idx_d;
      rd_idx_q     <= rd_idx_d;
      rdy_valid_q  <= rdy_valid_d;
      wr_started_q <= wr_started_d;
      wr_evt_q     <= wr_evt_d;
      rd_evt_q     <= rd_evt_d;
      wr_fire_q    <= wr_fire_d;
      rd_fire_q    <= rd_fire_d;
    end
  end

  // Register addresses from indices, and start or restart load pulses alongside the new addresses.
  always_comb begin
    wr_addr_d     = buf_addr(wr_idx_q, 1'b0);
    wr_max_d      = buf_addr(wr_idx_q, 1'b1);
    rd_addr_d     = buf_addr(rd_idx_q, 1'b0);
    rd_max_d      = buf_addr(rd_idx_q, 1'b1);
    wr_load_cnt_d = (wr_load_cnt_q != 4'd0) ? wr_load_cnt_q - 4'd1 : 4'd0;
    rd_load_cnt_d = (rd_load_cnt_q != 4'd0) ? rd_load_cnt_q - 4'd1 : 4'd0;
    if (wr_fire_q) wr_load_cnt_d = LOAD_INIT;
    if (rd_fire_q) rd_load_cnt_d = LOAD_INIT;
    if (!en_on) begin
      wr_addr_d     = BUF0_ADDR;
      wr_max_d      = BUF1_ADDR;
      rd_addr_d     = BUF2_ADDR;
      rd_max_d      = BUF3_ADDR;
      wr_load_cnt_d = 4'd0;
      rd_load_cnt_d = 4'd0;
    end
  end

  // Output registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_addr_q     <= BUF0_ADDR;
      wr_max_q      <= BUF1_ADDR;
      rd_addr_q     <= BUF2_ADDR;
      rd_max_q      <= BUF3_ADDR;
      wr_load_cnt_q <= 4'd0;
      rd_load_cnt_q <= 4'd0;
    end else begin
      wr_addr_q     <= wr_addr_d;
      wr_max_q      <= wr_max_d;
      rd_addr_q     <= rd_addr_d;
      rd_max_q      <= rd_max_d;
      wr_load_cnt_q <= wr_load_cnt_d;
      rd_load_cnt_q <= rd_load_cnt_d;
    end
  end

`ifdef FRAME_BUF_SCHED_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] rep_cnt_q, rep_cnt_d;

  // Saturating statistics. A drop is a started write that lands on a still-pending frame after any same-cycle read.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    if (rd_evt_q && !rdy_valid_q && (rep_cnt_q != 16'hFFFF))
      rep_cnt_d = rep_cnt_q + 16'd1;
    if (wr_evt_q && wr_started_q && rdy_valid_q && !rd_evt_q && (drop_cnt_q != 16'hFFFF))
      drop_cnt_d = drop_cnt_q + 16'd1;
    if (!en_on) begin
      drop_cnt_d = 16'd0;
      rep_cnt_d  = 16'd0;
    end
  end

  // Statistics registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      drop_cnt_q <= 16'd0;
      rep_cnt_q  <= 16'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign rep_cnt  = rep_cnt_q;
`else
  assign drop_cnt = 16'd0;
  assign rep_cnt  = 16'd0;
`endif

  assign wr_addr     = wr_addr_q;
  assign wr_max_addr = wr_max_q;
  assign rd_addr     = rd_addr_q;
  assign rd_max_addr = rd_max_q;
  assign wr_load     = en_on && (wr_load_cnt_q != 4'd0);
  assign rd_load     = en_on && (rd_load_cnt_q != 4'd0);
  assign wr_idx      = wr_idx_q;
  assign rd_idx      = rd_idx_q;
  assign rdy_idx     = rdy_idx_q;
  assign rdy_valid   = rdy_valid_q;

endmodule

// File: tb/tb_frame_buf_sched.sv
// tb_frame_buf_sched: randomized vsync stimulus for frame_buf_sched, checked against a buffer-role model.
// Latency: the load window is expected to cover cycles 5..8 after each input edge.
// Backpressure: none. Each transaction runs for a fixed cycle count.
module tb_frame_buf_sched;
  localparam int FS     = 921600;
  localparam int BASE   = 0;
  localparam int ADDR_W = 24;
  localparam int LOADC  = 4;
  localparam int ROLE_W = 0;  // buffer being written by the camera
  localparam int ROLE_Y = 1;  // ready frame (if pending) or spare
  localparam int ROLE_R = 2;  // buffer being displayed

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              wr_vs = 1'b0;
  logic              rd_vs = 1'b0;
  logic [ADDR_W-1:0] wr_addr, wr_max_addr, rd_addr, rd_max_addr;
  logic              wr_load, rd_load, rdy_valid;
  logic [1:0]        wr_idx, rd_idx, rdy_idx;
  logic [15:0]       drop_cnt, rep_cnt;

  frame_buf_sched dut (
    .Clk(clk), .Rst_n(rst_n), .En(en), .wr_vsync(wr_vs), .rd_vsync(rd_vs),
    .wr_addr(wr_addr), .wr_max_addr(wr_max_addr), .wr_load(wr_load),
    .rd_addr(rd_addr), .rd_max_addr(rd_max_addr), .rd_load(rd_load),
    .wr_idx(wr_idx), .rd_idx(rd_idx), .rdy_idx(rdy_idx), .rdy_valid(rdy_valid),
    .drop_cnt(drop_cnt), .rep_cnt(rep_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model: each of the three buffers holds a role, plus the pending flag and the statistics.
  int role[3];
  bit m_pend, m_started;
  int m_drop, m_rep;

  function automatic int who(input int r);
    for (int b = 0; b < 3; b++) if (role[b] == r) return b;
    return -1;
  endfunction

  function automatic int exp_cnt(input int v);
`ifdef FRAME_BUF_SCHED_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic m_reset();
    role[0] = ROLE_W; role[1] = ROLE_Y; role[2] = ROLE_R;
    m_pend = 0; m_started = 0; m_drop = 0; m_rep = 0;
  endtask

  task automatic m_read();
    int by, br;
    if (m_pend) begin
      by = who(ROLE_Y); br = who(ROLE_R);
      role[by] = ROLE_R; role[br] = ROLE_Y; m_pend = 0;
    end else begin
      m_rep = sat_inc(m_rep);
    end
  endtask

  task automatic m_write();
    int bw, by;
    if (!m_started) begin
      m_started = 1;
    end else begin
      if (m_pend) m_drop = sat_inc(m_drop);
      bw = who(ROLE_W); by = who(ROLE_Y);
      role[bw] = ROLE_Y; role[by] = ROLE_W; m_pend = 1;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".wr_idx"},    32'(wr_idx),      32'(who(ROLE_W)));
    chk({tag, ".rd_idx"},    32'(rd_idx),      32'(who(ROLE_R)));
    chk({tag, ".rdy_idx"},   32'(rdy_idx),     32'(who(ROLE_Y)));
    chk({tag, ".rdy_valid"}, 32'(rdy_valid),   32'(m_pend));
    chk({tag, ".wr_addr"},   32'(wr_addr),     32'(BASE + who(ROLE_W) * FS));
    chk({tag, ".wr_max"},    32'(wr_max_addr), 32'(BASE + (who(ROLE_W) + 1) * FS));
    chk({tag, ".rd_addr"},   32'(rd_addr),     32'(BASE + who(ROLE_R) * FS));
    chk({tag, ".rd_max"},    32'(rd_max_addr), 32'(BASE + (who(ROLE_R) + 1) * FS));
    chk({tag, ".drop_cnt"},  32'(drop_cnt),    32'(exp_cnt(m_drop)));
    chk({tag, ".rep_cnt"},   32'(rep_cnt),     32'(exp_cnt(m_rep)));
    chk({tag, ".wr_load"},   32'(wr_load),     32'd0);
    chk({tag, ".rd_load"},   32'(rd_load),     32'd0);
  endtask

  // One vsync transaction: raise the selected vsyncs for 3 cycles, then watch the load window and addresses.
  task automatic step(input bit dw, input bit dr);
    if (dr) m_read();
    if (dw) m_write();
    @(posedge clk); #1;
    wr_vs = dw; rd_vs = dr;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 3) begin wr_vs = 1'b0; rd_vs = 1'b0; end
      chk("step.wr_load", 32'(wr_load), 32'(dw && k >= 5 && k < 5 + LOADC));
      chk("step.rd_load", 32'(rd_load), 32'(dr && k >= 5 && k < 5 + LOADC));
      if (k == 5 && dw) chk("step.wr_addr_at_load", 32'(wr_addr), 32'(BASE + who(ROLE_W) * FS));
      if (k == 5 && dr) chk("step.rd_addr_at_load", 32'(rd_addr), 32'(BASE + who(ROLE_R) * FS));
    end
    check_state("step");
  endtask

  // Start a write load, then pulse Rst_n low in the middle of it.
  task automatic reset_mid_load();
    @(posedge clk); #1;
    wr_vs = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 3) wr_vs = 1'b0;
    end
    chk("rst.load_before", 32'(wr_load), 32'd1);
    rst_n = 1'b0;
    #1;
    m_reset();
    check_state("rst.during");
    chk("rst.rd_addr", 32'(rd_addr), 32'd1843200);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_state("rst.after");
  endtask

  // Start a write load, then drop En in the middle of it. Check that a vsync while disabled is ignored.
  task automatic en_drop_mid_load();
    @(posedge clk); #1;
    wr_vs = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 3) wr_vs = 1'b0;
      if (k == 6) begin
        chk("en.load_before", 32'(wr_load), 32'd1);
        en = 1'b0;
      end
      if (k == 8) chk("en.load_forced", 32'(wr_load), 32'd0);
    end
    m_reset();
    check_state("en.low");
    chk("en.rd_addr", 32'(rd_addr), 32'd1843200);
    wr_vs = 1'b1; rd_vs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    wr_vs = 1'b0; rd_vs = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_state("en.ignored");
    en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_state("en.back");
  endtask

  initial begin
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check_state("reset");
    chk("reset.rd_addr", 32'(rd_addr), 32'd1843200);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    repeat (4) @(posedge clk);

    // Directed sequence covering the documented scenarios.
    step(1'b1, 1'b0);
    chk("start.wr_addr", 32'(wr_addr), 32'd0);
    chk("start.rdy_valid", 32'(rdy_valid), 32'd0);
    step(1'b1, 1'b0);
    chk("f1.rdy_idx", 32'(rdy_idx), 32'd0);
    chk("f1.rdy_valid", 32'(rdy_valid), 32'd1);
    chk("f1.wr_idx", 32'(wr_idx), 32'd1);
    chk("f1.wr_addr", 32'(wr_addr), 32'd921600);
    step(1'b0, 1'b1);
    chk("r1.rd_idx", 32'(rd_idx), 32'd0);
    chk("r1.rd_addr", 32'(rd_addr), 32'd0);
    chk("r1.rdy_idx", 32'(rdy_idx), 32'd2);
    chk("r1.rdy_valid", 32'(rdy_valid), 32'd0);
    repeat (3) step(1'b1, 1'b0);
    chk("drop.rd_idx", 32'(rd_idx), 32'd0);
    repeat (2) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    reset_mid_load();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    en_drop_mid_load();

    // Randomized traffic with occasional disables.
    for (int i = 0; i < 40; i++) begin
      int sel;
      bit dw, dr;
      sel = $urandom_range(0, 11);
      if (sel == 0) begin
        en_drop_mid_load();
      end else begin
        dw = 1'($urandom_range(0, 1));
        dr = 1'($urandom_range(0, 1));
        if (!dw && !dr) dw = 1'b1;
        step(dw, dr);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
